// File: rtl/game_pkg.sv
// Shared definitions for the falling-block game engine: operation codes,
// button indices and the 4-bit operation type.
package game_pkg;

  typedef logic [3:0] op_t;

  // Engine command codes; left and start share a code on purpose
  localparam op_t OP_NONE   = 4'd0;
  localparam op_t OP_LEFT   = 4'd1;
  localparam op_t OP_START  = 4'd1;
  localparam op_t OP_RIGHT  = 4'd2;
  localparam op_t OP_ROTATE = 4'd3;
  localparam op_t OP_DROP   = 4'd5;

  // Bit positions within btn_raw
  localparam int NUM_BTNS   = 5;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_ROTATE = 2;
  localparam int BTN_DROP   = 3;
  localparam int BTN_START  = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser followed by a debouncer that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
// rise pulses for one cycle together with the debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          rise_reg;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[0], raw};
  end

  // Count consecutive disagreeing cycles; any agreement (bounce) restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (sync_reg[1] != level_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_reg <= sync_reg[1];
          rise_reg  <= sync_reg[1];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/frame_input_ctrl.sv
// Input stage: debounces five buttons, keeps one pending flag per button,
// and on each vsync falling edge issues the highest-priority pending button
// as an operation code while advancing framenumber.
// Optional feature macro: INPUT_AUTOREPEAT_EN (auto-repeat for left/right/drop).
module frame_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_FRAMES = 16,
  parameter int REPEAT_RATE_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic       vsync,
  output logic [3:0] operation,
  output logic [9:0] framenumber
);

  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] rep_set;
  logic [NUM_BTNS-1:0] pending_reg;
  logic [NUM_BTNS-1:0] pending_next;
  logic [NUM_BTNS-1:0] clr;
  logic [2:0]          vs_sync_reg;
  logic                tick_reg;
  op_t                 arb_op;
  op_t                 op_reg;
  logic [9:0]          fn_reg;
  logic                unused_levels;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_raw[gi]),
        .level(level[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  // Only the repeatable buttons look at the held level
  assign unused_levels = ^level;

  // Synchronise vsync; the third stage gives the previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_sync_reg <= '0;
    else        vs_sync_reg <= {vs_sync_reg[1:0], vsync};
  end

  // One-cycle frame tick on a synchronised vsync falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_reg <= 1'b0;
    else        tick_reg <= vs_sync_reg[2] & ~vs_sync_reg[1];
  end

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES + 1);

  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_rep
      if (gi == BTN_LEFT || gi == BTN_RIGHT || gi == BTN_DROP) begin : g_on
        logic [RW-1:0] rep_cnt_reg;
        logic          at_wrap;
        logic          at_delay;

        // After the first repeat the counter loops DELAY .. DELAY+RATE-1
        assign at_wrap  = (rep_cnt_reg == RW'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES - 1));
        assign at_delay = (rep_cnt_reg == RW'(REPEAT_DELAY_FRAMES - 1));
        assign rep_set[gi] = tick_reg & level[gi] & (at_wrap | at_delay);

        // Count held frames; release clears the count but leaves pending alone
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)         rep_cnt_reg <= '0;
          else if (!level[gi]) rep_cnt_reg <= '0;
          else if (tick_reg)  rep_cnt_reg <= at_wrap ? RW'(REPEAT_DELAY_FRAMES)
                                                     : rep_cnt_reg + RW'(1);
        end
      end else begin : g_off
        assign rep_set[gi] = 1'b0;
      end
    end
  endgenerate
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES;
  assign rep_set = '0;
`endif

  // Fixed-priority pick: rotate > left > start > right > drop
  always_comb begin
    arb_op = OP_NONE;
    clr    = '0;
    if (pending_reg[BTN_ROTATE]) begin
      arb_op          = OP_ROTATE;
      clr[BTN_ROTATE] = 1'b1;
    end else if (pending_reg[BTN_LEFT]) begin
      arb_op        = OP_LEFT;
      clr[BTN_LEFT] = 1'b1;
    end else if (pending_reg[BTN_START]) begin
      arb_op         = OP_START;
      clr[BTN_START] = 1'b1;
    end else if (pending_reg[BTN_RIGHT]) begin
      arb_op         = OP_RIGHT;
      clr[BTN_RIGHT] = 1'b1;
    end else if (pending_reg[BTN_DROP]) begin
      arb_op        = OP_DROP;
      clr[BTN_DROP] = 1'b1;
    end
  end

  // Sets win over a same-cycle clear, so a coinciding repeat is not lost
  always_comb begin
    pending_next = pending_reg;
    if (tick_reg) pending_next = pending_next & ~clr;
    pending_next = pending_next | rise | rep_set;
  end

  // Pending flags update every cycle; outputs only move on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      op_reg      <= OP_NONE;
      fn_reg      <= '0;
    end else begin
      pending_reg <= pending_next;
      if (tick_reg) begin
        op_reg <= arb_op;
        fn_reg <= fn_reg + 10'd1;
      end
    end
  end

  assign operation   = op_reg;
  assign framenumber = fn_reg;

endmodule

// File: tb/tb_frame_input_ctrl.sv
// Directed bench for frame_input_ctrl with short debounce/repeat settings.
// Expectations follow INPUT_AUTOREPEAT_EN the same way the design does.
module tb_frame_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = 5'b0;
  logic       vsync = 1'b0;
  logic [3:0] operation;
  logic [9:0] framenumber;

  int n_vec  = 0;
  int n_err  = 0;
  int fn_exp = 0;
  int exp_rep[10];

  frame_input_ctrl #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .vsync      (vsync),
    .operation  (operation),
    .framenumber(framenumber)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One video frame: vsync pulse, then wait for the tick and output update
  task automatic frame(input string tag, input int exp_op, input bit chk);
    vsync = 1'b1;
    idle(4);
    vsync = 1'b0;
    idle(6);
    fn_exp = (fn_exp + 1) % 1024;
    if (chk) begin
      check({tag, " op"}, 32'(operation), 32'(exp_op));
      check({tag, " fn"}, 32'(framenumber), 32'(fn_exp));
    end
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    btn_raw = btn_raw | mask;
    idle(hold);
    btn_raw = btn_raw & ~mask;
    idle(10);
  endtask

  initial begin
`ifdef INPUT_AUTOREPEAT_EN
    exp_rep = '{2, 0, 0, 2, 0, 2, 0, 2, 0, 2};
`else
    exp_rep = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset values
    idle(2);
    check("reset op", 32'(operation), 32'd0);
    check("reset fn", 32'(framenumber), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Simple tap so outputs are non-zero before the mid-frame reset
    press(5'b00001, 8);
    frame("left tap", 1, 1'b1);

    // Reset mid-frame with rotate pending
    press(5'b00100, 8);
    vsync = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst op", 32'(operation), 32'd0);
    check("midrst fn", 32'(framenumber), 32'd0);
    fn_exp = 0;
    idle(2);
    vsync = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    frame("post-rst", 0, 1'b1);

    // Bounce: runs of two never reach the debounce threshold
    for (int i = 0; i < 20; i++) begin
      btn_raw[0] = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    btn_raw[0] = 1'b0;
    idle(4);
    frame("bounce only", 0, 1'b1);
    press(5'b00001, 6);
    frame("tap after bounce", 1, 1'b1);
    frame("tap done", 0, 1'b1);

    // Priority among left, right, rotate
    press(5'b00111, 8);
    frame("prio 1", 3, 1'b1);
    frame("prio 2", 1, 1'b1);
    frame("prio 3", 2, 1'b1);
    frame("prio 4", 0, 1'b1);

    // Left and start share code 1: issued on two successive frames
    press(5'b10001, 8);
    frame("left+start 1", 1, 1'b1);
    frame("left+start 2", 1, 1'b1);
    frame("left+start 3", 0, 1'b1);

    // Drop code
    press(5'b01000, 8);
    frame("drop", 5, 1'b1);
    frame("drop done", 0, 1'b1);

    // Auto-repeat of right held for 10 frames
    btn_raw[1] = 1'b1;
    idle(10);
    for (int i = 0; i < 10; i++) begin
      frame($sformatf("repeat f%0d", i + 1), exp_rep[i], 1'b1);
    end
    btn_raw[1] = 1'b0;
    idle(10);
    frame("repeat released", 0, 1'b1);

    // Drop pending lands on the tick cycle: not issued until the frame after
    vsync = 1'b1;
    idle(4);
    btn_raw[3] = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(6);
    fn_exp = (fn_exp + 1) % 1024;
    check("collide tick op", 32'(operation), 32'd0);
    check("collide tick fn", 32'(framenumber), 32'(fn_exp));
    btn_raw[3] = 1'b0;
    idle(10);
    frame("collide next", 5, 1'b1);
    frame("collide after", 0, 1'b1);

    // Frame counter wrap
    while (fn_exp != 1023) frame("", 0, 1'b0);
    check("pre-wrap fn", 32'(framenumber), 32'd1023);
    frame("wrap", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_input_ctrl.md
# frame_input_ctrl

Upstream input stage for the falling-block game engine. Samples five raw push-buttons, debounces them, and converts presses into one 4-bit `operation` code per video frame. Also maintains the free-running `framenumber` the engine uses for piece selection. Outputs are updated just after each vsync falling edge, so they are stable across the next vsync rising edge, where the engine samples them.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable `clk` cycles required to accept a button level (10 ms at 25 MHz).
- `REPEAT_DELAY_FRAMES`, default 16: frames a repeatable button must be held before the first auto-repeat.
- `REPEAT_RATE_FRAMES`, default 4: frames between later auto-repeats.
- `clk` in 1: pixel clock. Single clock domain.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `btn_raw` in 5: asynchronous buttons, active-high. Bit 0 = left, 1 = right, 2 = rotate, 3 = drop, 4 = start.
- `vsync` in 1: video vertical sync, asynchronous to the logic, active-high.
- `operation` out 4: engine command for the current frame. 0 = none, 1 = left/start, 2 = right, 3 = rotate, 5 = soft drop.
- `framenumber` out 10: frame counter.

## Operation
- **Button path.** Each button goes through a 2-flop synchroniser and then a debouncer.
  - A debouncer's state changes only after the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts its counter.
- **Pending events.** Each button has a 1-bit pending flag, set on the debounced rising edge.
  - The flag is a single bit: repeated presses before issue do not accumulate.
  - The flag survives button release, so short taps are never lost.
- **Auto-repeat** (left, right, drop only). While a button is held, a per-button frame counter runs.
  - When it reaches `REPEAT_DELAY_FRAMES`, the pending flag is set.
  - After that, the flag is set every `REPEAT_RATE_FRAMES` frames.
  - Release clears the counter but not the pending flag.
- **Frame tick.** One-cycle pulse on a falling edge of the synchronised vsync.
  - `framenumber` increments and wraps from 1023 to 0.
  - Arbitration picks the highest-priority pending flag: rotate > left > start > right > drop.
  - `operation` takes that flag's code and only that flag is cleared. Others stay pending for later frames.
  - If nothing is pending, `operation` becomes 0.
- **Code sharing.** Left and start both map to code 1, and the engine interprets the code by its own state. If both are pending, left is issued first and start on the next tick.

## Timing
- Reset values: `operation` = 0, `framenumber` = 0, all debounced states 0, pending flags 0, repeat counters 0, synchronisers 0.
- Reset asserted mid-frame clears all state immediately. The first tick after release arbitrates an empty set.
- Press latency: raw edge → synchroniser (2 cycles) → debounce (`DEBOUNCE_CYCLES`) → pending set 1 cycle later.
- Tick latency: vsync falling edge → tick detected 3 cycles later → `operation`/`framenumber` registered on the next cycle.
- `operation` and `framenumber` change only on the cycle after a tick, and hold for the whole frame.
- Same-cycle collisions:
  - A pending flag set on the tick cycle is not eligible until the next tick.
  - An auto-repeat set that coincides with the clear of the same flag leaves the flag set.
- Arbitration and the repeat counters advance on the same tick.

## Configuration
- `INPUT_AUTOREPEAT_EN` defined: auto-repeat logic and per-button repeat counters are present, as described under Operation.
- Not defined: repeat logic is removed, so only debounced rising edges set pending flags. `REPEAT_DELAY_FRAMES` and `REPEAT_RATE_FRAMES` are ignored.

## Structure
- Shared package `game_pkg` holds:
  - operation code constants: `OP_NONE` = 0, `OP_LEFT` = 1, `OP_START` = 1, `OP_RIGHT` = 2, `OP_ROTATE` = 3, `OP_DROP` = 5;
  - button index constants;
  - operation typedef (4-bit).
- One sub-module, `btn_debounce`, containing the synchroniser and debounce counter for one button. It is instantiated five times.
- Pending flags, repeat counters, frame tick detection and arbitration live in the top module.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_FRAMES`=3, `REPEAT_RATE_FRAMES`=2, unless stated otherwise.
- **Reset mid-frame:** assert `rst_n`=0 with a rotate pending → `operation`=0 and `framenumber`=0 immediately; next tick outputs `operation`=0.
- **Bounce and tap:** left toggles every 2 cycles for 20 cycles, then held 6 cycles and released → exactly one `operation`=1 frame, then 0.
- **Priority:** left, right and rotate debounced in the same frame → next three frames give `operation` 3, 1, 2, then 0.
- **Auto-repeat:** right held 10 frames → `operation`=2 on the first frame, then on frames 4, 6, 8, 10; 0 elsewhere. With `INPUT_AUTOREPEAT_EN` undefined, only the first frame gives 2.
- **Wrap and collision:**
  - Run 1024 frames → `framenumber` goes 1023 → 0.
  - Drop debounce completing on the tick cycle → `operation`=5 only on the following frame.
